// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with per-entry busy scoreboard, write-through bypass
// and a registered busy counter. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_2r1w #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    output logic             rbusy0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             rbusy1,
    output logic [AW:0]      busy_cnt,
    output logic             all_idle
);

`ifdef REGFILE_ZERO_REG_EN
    localparam int LO = 1;
`else
    localparam int LO = 0;
`endif

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_busy_cnt;
    logic             r_all_idle;

    logic [DEPTH-1:0] w_wsel;
    logic [DEPTH-1:0] w_rsel;
    logic             w_inc;
    logic             w_dec;
    logic [AW:0]      w_cnt_next;
    logic [AW-1:0]    w_raddr [2];
    logic [WIDTH-1:0] w_rdata [2];
    logic             w_rbusy [2];

    // Out-of-range indices match no entry, so they fall out of every select for free.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            if (gi < LO) begin : g_hard
                assign w_wsel[gi] = 1'b0;
                assign w_rsel[gi] = 1'b0;
            end else begin : g_ent
                assign w_wsel[gi] = we  && (waddr    == AW'(gi));
                assign w_rsel[gi] = rsv && (rsv_addr == AW'(gi));
            end
        end
    endgenerate

    // A same-index write+reserve leaves the entry busy, so it never counts as a release.
    assign w_inc = |(w_rsel & ~r_busy);
    assign w_dec = |(w_wsel & r_busy & ~w_rsel);

    always_comb begin
        w_cnt_next = r_busy_cnt;
        if (w_inc && !w_dec) begin
            w_cnt_next = r_busy_cnt + (AW+1)'(1);
        end else if (w_dec && !w_inc) begin
            w_cnt_next = r_busy_cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_all_idle <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wsel[i]) begin
                    r_mem[i] <= wdata;
                end
                if (w_rsel[i]) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wsel[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
            r_busy_cnt <= w_cnt_next;
            r_all_idle <= (w_cnt_next == '0);
        end
    end

    assign w_raddr[0] = raddr0;
    assign w_raddr[1] = raddr1;

    // Bypass reports idle even when the same index is being reserved this cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = '0;
            w_rbusy[p] = 1'b0;
            for (int i = LO; i < DEPTH; i++) begin
                if (w_raddr[p] == AW'(i)) begin
                    if (w_wsel[i]) begin
                        w_rdata[p] = wdata;
                        w_rbusy[p] = 1'b0;
                    end else begin
                        w_rdata[p] = r_mem[i];
                        w_rbusy[p] = r_busy[i];
                    end
                end
            end
        end
    end

    assign rdata0   = w_rdata[0];
    assign rbusy0   = w_rbusy[0];
    assign rdata1   = w_rdata[1];
    assign rbusy1   = w_rbusy[1];
    assign busy_cnt = r_busy_cnt;
    assign all_idle = r_all_idle;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w (DEPTH=5, AW=3): directed scenarios plus a
// randomized run against an array-based reference model.
module tb_regfile_2r1w;

    localparam int W = 8;
    localparam int D = 5;
    localparam int A = 3;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr;
    logic         we;
    logic [A-1:0] waddr;
    logic [W-1:0] wdata;
    logic         rsv;
    logic [A-1:0] rsv_addr;
    logic [A-1:0] raddr0;
    logic [W-1:0] rdata0;
    logic         rbusy0;
    logic [A-1:0] raddr1;
    logic [W-1:0] rdata1;
    logic         rbusy1;
    logic [A:0]   busy_cnt;
    logic         all_idle;

    int n_checks = 0;
    int n_err    = 0;
    int n_txn    = 0;

    logic [W-1:0] m_mem  [D];
    bit           m_busy [D];

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv(rsv), .rsv_addr(rsv_addr),
        .raddr0(raddr0), .rdata0(rdata0), .rbusy0(rbusy0),
        .raddr1(raddr1), .rdata1(rdata1), .rbusy1(rbusy1),
        .busy_cnt(busy_cnt), .all_idle(all_idle)
    );

    function automatic bit addr_ok(input int a);
        return (a < D) && !(ZR && a == 0);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // {busy, data} a read port should show right now, bypass included
    function automatic logic [W:0] exp_read(input int a);
        if (!addr_ok(a)) return '0;
        if (we && addr_ok(int'(waddr)) && int'(waddr) == a) return {1'b0, wdata};
        return {m_busy[a], m_mem[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        $display("txn %0d: clr=%0b we=%0b waddr=%0d wdata=%02h rsv=%0b rsv_addr=%0d",
                 n_txn, clr, we, waddr, wdata, rsv, rsv_addr);
        n_txn++;
        if (clr) begin
            model_reset();
        end else begin
            if (we && addr_ok(int'(waddr))) begin
                m_mem[waddr]  = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (rsv && addr_ok(int'(rsv_addr))) m_busy[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; we = 1'b0; waddr = '0; wdata = '0; rsv = 1'b0; rsv_addr = '0;
        raddr0 = 3'd1; raddr1 = 3'd2;
        model_reset();
        #3;
        n_checks++;
        if (busy_cnt !== 4'd0 || all_idle !== 1'b1) begin
            n_err++; $display("FAIL reset_cnt: busy_cnt=%0d all_idle=%0b, want 0/1", busy_cnt, all_idle);
        end
        n_checks++;
        if (rdata0 !== 8'h00 || rbusy0 !== 1'b0 || rdata1 !== 8'h00) begin
            n_err++; $display("FAIL reset_read: rdata0=%02h rbusy0=%0b rdata1=%02h, want 00/0/00", rdata0, rbusy0, rdata1);
        end
        tick();
        clr = 1'b0;
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 3'd1; wdata = 8'hA5;
        tick();
        waddr = 3'd2; wdata = 8'h3C;
        tick();
        we = 1'b0; raddr0 = 3'd1; raddr1 = 3'd2;
        #1;
        n_checks++;
        if (rdata0 !== 8'hA5 || rdata1 !== 8'h3C) begin
            n_err++; $display("FAIL write_read: rdata0=%02h rdata1=%02h, want A5/3C", rdata0, rdata1);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 3'd3; wdata = 8'h7E; raddr0 = 3'd3;
        #1;
        n_checks++;
        if (rdata0 !== 8'h7E || rbusy0 !== 1'b0) begin
            n_err++; $display("FAIL bypass: rdata0=%02h rbusy0=%0b, want 7E/0", rdata0, rbusy0);
        end
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata0 !== 8'h7E) begin
            n_err++; $display("FAIL bypass_stored: rdata0=%02h, want 7E", rdata0);
        end
    endtask

    task automatic test_reserve();
        rsv = 1'b1; rsv_addr = 3'd1; raddr0 = 3'd1;
        tick();
        rsv = 1'b0;
        #1;
        n_checks++;
        if (rbusy0 !== 1'b1 || busy_cnt !== 4'd1 || all_idle !== 1'b0) begin
            n_err++; $display("FAIL reserve: rbusy0=%0b busy_cnt=%0d all_idle=%0b, want 1/1/0", rbusy0, busy_cnt, all_idle);
        end
        we = 1'b1; waddr = 3'd1; wdata = 8'h11;
        #1;
        n_checks++;
        if (rbusy0 !== 1'b0 || rdata0 !== 8'h11) begin
            n_err++; $display("FAIL release_bypass: rbusy0=%0b rdata0=%02h, want 0/11", rbusy0, rdata0);
        end
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rbusy0 !== 1'b0 || busy_cnt !== 4'd0 || all_idle !== 1'b1) begin
            n_err++; $display("FAIL release: rbusy0=%0b busy_cnt=%0d all_idle=%0b, want 0/0/1", rbusy0, busy_cnt, all_idle);
        end
    endtask

    task automatic test_rsv_busy();
        rsv = 1'b1; rsv_addr = 3'd2;
        tick();
        tick();
        rsv = 1'b0;
        #1;
        n_checks++;
        if (busy_cnt !== 4'd1) begin
            n_err++; $display("FAIL rsv_twice: busy_cnt=%0d, want 1", busy_cnt);
        end
        we = 1'b1; waddr = 3'd2; wdata = 8'h5A; rsv = 1'b1; rsv_addr = 3'd2; raddr0 = 3'd2;
        #1;
        n_checks++;
        if (rdata0 !== 8'h5A || rbusy0 !== 1'b0) begin
            n_err++; $display("FAIL same_idx_bypass: rdata0=%02h rbusy0=%0b, want 5A/0", rdata0, rbusy0);
        end
        tick();
        we = 1'b0; rsv = 1'b0;
        #1;
        n_checks++;
        if (rdata0 !== 8'h5A || rbusy0 !== 1'b1 || busy_cnt !== 4'd1) begin
            n_err++; $display("FAIL same_idx: rdata0=%02h rbusy0=%0b busy_cnt=%0d, want 5A/1/1", rdata0, rbusy0, busy_cnt);
        end
        we = 1'b1; waddr = 3'd2; wdata = 8'h66; rsv = 1'b1; rsv_addr = 3'd3; raddr1 = 3'd3;
        tick();
        we = 1'b0; rsv = 1'b0;
        #1;
        n_checks++;
        if (rdata0 !== 8'h66 || rbusy0 !== 1'b0 || rbusy1 !== 1'b1 || busy_cnt !== 4'd1) begin
            n_err++; $display("FAIL diff_idx: rdata0=%02h rbusy0=%0b rbusy1=%0b busy_cnt=%0d, want 66/0/1/1",
                              rdata0, rbusy0, rbusy1, busy_cnt);
        end
        we = 1'b1; waddr = 3'd3; wdata = 8'h7E;
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (busy_cnt !== 4'd0 || all_idle !== 1'b1) begin
            n_err++; $display("FAIL idle_again: busy_cnt=%0d all_idle=%0b, want 0/1", busy_cnt, all_idle);
        end
    endtask

    task automatic test_out_of_range();
        we = 1'b1; waddr = 3'd6; wdata = 8'hFF; rsv = 1'b1; rsv_addr = 3'd6;
        raddr0 = 3'd6; raddr1 = 3'd5;
        #1;
        n_checks++;
        if (rdata0 !== 8'h00 || rbusy0 !== 1'b0 || rdata1 !== 8'h00) begin
            n_err++; $display("FAIL oor_read: rdata0=%02h rbusy0=%0b rdata1=%02h, want 00/0/00", rdata0, rbusy0, rdata1);
        end
        tick();
        we = 1'b0; rsv = 1'b0; raddr1 = 3'd1;
        #1;
        n_checks++;
        if (busy_cnt !== 4'd0 || rdata0 !== 8'h00 || rdata1 !== 8'h11) begin
            n_err++; $display("FAIL oor_write: busy_cnt=%0d rdata0=%02h rdata1=%02h, want 0/00/11", busy_cnt, rdata0, rdata1);
        end
        we = 1'b1; waddr = 3'd4; wdata = 8'hC3; rsv = 1'b1; rsv_addr = 3'd4; raddr0 = 3'd4;
        tick();
        we = 1'b0; rsv = 1'b0;
        #1;
        n_checks++;
        if (rdata0 !== 8'hC3 || rbusy0 !== 1'b1 || busy_cnt !== 4'd1) begin
            n_err++; $display("FAIL last_entry: rdata0=%02h rbusy0=%0b busy_cnt=%0d, want C3/1/1", rdata0, rbusy0, busy_cnt);
        end
        we = 1'b1; waddr = 3'd4;
        tick();
        we = 1'b0;
    endtask

    task automatic test_zero_reg();
        logic [W-1:0] exp_d;
        logic [A:0]   exp_c;
        exp_d = ZR ? 8'h00 : 8'hFF;
        exp_c = ZR ? 4'd0 : 4'd1;
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr0 = 3'd0;
        #1;
        n_checks++;
        if (rdata0 !== exp_d) begin
            n_err++; $display("FAIL zero_bypass: rdata0=%02h, want %02h", rdata0, exp_d);
        end
        tick();
        we = 1'b0; rsv = 1'b1; rsv_addr = 3'd0;
        tick();
        rsv = 1'b0;
        #1;
        n_checks++;
        if (rdata0 !== exp_d || rbusy0 !== ~ZR || busy_cnt !== exp_c) begin
            n_err++; $display("FAIL zero_reg: rdata0=%02h rbusy0=%0b busy_cnt=%0d, want %02h/%0b/%0d",
                              rdata0, rbusy0, busy_cnt, exp_d, ~ZR, exp_c);
        end
        we = 1'b1; waddr = 3'd0; wdata = 8'h00;
        tick();
        we = 1'b0;
    endtask

    task automatic test_clr_mid();
        we = 1'b1; waddr = 3'd1; wdata = 8'hA5; rsv = 1'b1; rsv_addr = 3'd2;
        tick();
        we = 1'b1; waddr = 3'd3; wdata = 8'h42; rsv = 1'b1; rsv_addr = 3'd4;
        raddr0 = 3'd1; raddr1 = 3'd2;
        #1;
        n_checks++;
        if (busy_cnt !== 4'd1 || rdata0 !== 8'hA5) begin
            n_err++; $display("FAIL pre_clr: busy_cnt=%0d rdata0=%02h, want 1/A5", busy_cnt, rdata0);
        end
        #1;
        clr = 1'b1;
        #1;
        n_checks++;
        if (rdata0 !== 8'h00 || rdata1 !== 8'h00 || rbusy1 !== 1'b0 || busy_cnt !== 4'd0 || all_idle !== 1'b1) begin
            n_err++; $display("FAIL clr_async: rdata0=%02h rdata1=%02h rbusy1=%0b busy_cnt=%0d all_idle=%0b, want 00/00/0/0/1",
                              rdata0, rdata1, rbusy1, busy_cnt, all_idle);
        end
        tick();
        clr = 1'b0; we = 1'b0; rsv = 1'b0; raddr0 = 3'd3; raddr1 = 3'd4;
        #1;
        n_checks++;
        if (rdata0 !== 8'h00 || rbusy1 !== 1'b0 || busy_cnt !== 4'd0) begin
            n_err++; $display("FAIL clr_discard: rdata0=%02h rbusy1=%0b busy_cnt=%0d, want 00/0/0", rdata0, rbusy1, busy_cnt);
        end
    endtask

    task automatic test_random();
        logic [W:0] e0;
        logic [W:0] e1;
        for (int n = 0; n < 300; n++) begin
            we       = 1'($urandom_range(0, 1));
            waddr    = A'($urandom_range(0, 7));
            wdata    = W'($urandom);
            rsv      = ($urandom_range(0, 2) == 0);
            rsv_addr = A'($urandom_range(0, 7));
            raddr0   = ($urandom_range(0, 1) == 0) ? waddr : A'($urandom_range(0, 7));
            raddr1   = A'($urandom_range(0, 7));
            #1;
            e0 = exp_read(int'(raddr0));
            e1 = exp_read(int'(raddr1));
            n_checks++;
            if ({rbusy0, rdata0} !== e0) begin
                n_err++; $display("FAIL rnd_port0 @%0d: addr=%0d busy/data=%0b/%02h, want %0b/%02h",
                                  n, raddr0, rbusy0, rdata0, e0[W], e0[W-1:0]);
            end
            n_checks++;
            if ({rbusy1, rdata1} !== e1) begin
                n_err++; $display("FAIL rnd_port1 @%0d: addr=%0d busy/data=%0b/%02h, want %0b/%02h",
                                  n, raddr1, rbusy1, rdata1, e1[W], e1[W-1:0]);
            end
            tick();
            n_checks++;
            if (int'(busy_cnt) != m_count() || all_idle !== (m_count() == 0)) begin
                n_err++; $display("FAIL rnd_count @%0d: busy_cnt=%0d all_idle=%0b, want %0d/%0b",
                                  n, busy_cnt, all_idle, m_count(), (m_count() == 0));
            end
        end
        we = 1'b0; rsv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_reserve();
        test_rsv_busy();
        test_out_of_range();
        test_zero_reg();
        test_clr_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
